rtc_bus_sequencer: RTL and testbench

//  Parametrised multi-channel sequencer for the RTC multiplexed parallel bus.

---
 rtl/rtc_bus_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_rtc_bus_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_sequencer.sv
// Multi-channel round-robin sequencer driving the RTC multiplexed address/data bus.
// Optional macro RTC_CH0_PRIO_EN gives channel 0 strict priority over the round-robin channels.
module rtc_bus_sequencer #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned PHASE_CYC = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CH-1:0]    req_i,
    input  logic [NUM_CH-1:0]    we_i,
    input  logic [NUM_CH*DW-1:0] addr_i,
    input  logic [NUM_CH*DW-1:0] wdata_i,
    output logic [NUM_CH-1:0]    grant_o,
    output logic                 done_o,
    output logic [DW-1:0]        rdata_o,
    output logic                 busy_o,
    input  logic                 rst_req_i,
    output logic                 rst_ack_o,
    output logic                 cs_n_o,
    output logic                 rd_n_o,
    output logic                 wr_n_o,
    output logic                 ad_o,
    output logic [DW-1:0]        bus_out_o,
    output logic                 bus_oe_o,
    input  logic [DW-1:0]        bus_in_i
);

    localparam int unsigned CW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
    localparam int unsigned PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CW-1:0] CntLast = CW'(PHASE_CYC - 1);

    // Enumerator order matters: bus states advance by incrementing the encoding.
    typedef enum logic [2:0] {
        StIdle,
        StASet,
        StAStb,
        StAHld,
        StDSet,
        StDStb,
        StDHld,
        StDone
    } state_e;

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic [PW-1:0]     ptr_q;
    logic              we_q;
    logic [DW-1:0]     addr_q;
    logic [DW-1:0]     wdata_q;
    logic [NUM_CH-1:0] grant_q;
    logic              done_q;
    logic [DW-1:0]     rdata_q;
    logic              busy_q;
    logic              rst_ack_q;
    logic              cs_n_q;
    logic              rd_n_q;
    logic              wr_n_q;
    logic              ad_q;
    logic              bus_oe_q;
    logic [DW-1:0]     bus_out_q;

    logic [PW-1:0]     cand;
    logic [PW-1:0]     win_idx;
    logic [PW-1:0]     ptr_nxt;
    logic              win_vld;
    logic              ptr_upd;
    logic              we_sel;
    logic [DW-1:0]     addr_sel;
    logic [DW-1:0]     wdata_sel;
    logic [NUM_CH-1:0] win_oh;

    // Scan from the pointer downwards in priority so the nearest requester overwrites last.
    always_comb begin
        cand    = '0;
        win_idx = '0;
        ptr_upd = 1'b1;
        win_vld = (|req_i) && !rst_req_i;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            cand = PW'((int'(ptr_q) + k) % NUM_CH);
            if (req_i[cand]) begin
                win_idx = cand;
            end
        end
`ifdef RTC_CH0_PRIO_EN
        if (req_i[0]) begin
            win_idx = '0;
            ptr_upd = 1'b0;
        end
`endif
        ptr_nxt = PW'((int'(win_idx) + 1) % NUM_CH);
    end

    always_comb begin
        we_sel    = 1'b0;
        addr_sel  = '0;
        wdata_sel = '0;
        win_oh    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (win_idx == PW'(i)) begin
                we_sel    = we_i[i];
                addr_sel  = addr_i[i*DW +: DW];
                wdata_sel = wdata_i[i*DW +: DW];
                win_oh[i] = 1'b1;
            end
        end
    end

    // Bus outputs are decoded from the registered state, so they trail the state by one cycle;
    // grant is set directly on the arbitration edge, giving grant-to-done of 6*PHASE_CYC+1.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            ptr_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            grant_q   <= '0;
            done_q    <= 1'b0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            rst_ack_q <= 1'b0;
            cs_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            ad_q      <= 1'b0;
            bus_oe_q  <= 1'b0;
            bus_out_q <= '0;
        end else begin
            cs_n_q    <= 1'b1;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            ad_q      <= 1'b0;
            bus_oe_q  <= 1'b0;
            bus_out_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= (state_q != StIdle);
            rst_ack_q <= rst_req_i && (rst_ack_q || (state_q == StIdle));

            // Capture on the trailing edge of the visible read strobe.
            if (!rd_n_q && (state_q == StDHld)) begin
                rdata_q <= bus_in_i;
            end

            if ((state_q != StIdle) && (state_q != StDone)) begin
                if (cnt_q == CntLast) begin
                    cnt_q   <= '0;
                    state_q <= state_e'(state_q + 3'd1);
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (win_vld) begin
                        state_q <= StASet;
                        cnt_q   <= '0;
                        grant_q <= win_oh;
                        busy_q  <= 1'b1;
                        we_q    <= we_sel;
                        addr_q  <= addr_sel;
                        wdata_q <= wdata_sel;
                        if (ptr_upd) begin
                            ptr_q <= ptr_nxt;
                        end
                    end
                end
                StASet, StAHld: begin
                    bus_oe_q  <= 1'b1;
                    bus_out_q <= addr_q;
                end
                StAStb: begin
                    cs_n_q    <= 1'b0;
                    wr_n_q    <= 1'b0;
                    bus_oe_q  <= 1'b1;
                    bus_out_q <= addr_q;
                end
                StDSet, StDHld: begin
                    ad_q      <= 1'b1;
                    bus_oe_q  <= we_q;
                    bus_out_q <= we_q ? wdata_q : '0;
                end
                StDStb: begin
                    ad_q      <= 1'b1;
                    cs_n_q    <= 1'b0;
                    wr_n_q    <= !we_q;
                    rd_n_q    <= we_q;
                    bus_oe_q  <= we_q;
                    bus_out_q <= we_q ? wdata_q : '0;
                end
                StDone: begin
                    grant_q <= '0;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign grant_o   = grant_q;
    assign done_o    = done_q;
    assign rdata_o   = rdata_q;
    assign busy_o    = busy_q;
    assign rst_ack_o = rst_ack_q;
    assign cs_n_o    = cs_n_q;
    assign rd_n_o    = rd_n_q;
    assign wr_n_o    = wr_n_q;
    assign ad_o      = ad_q;
    assign bus_out_o = bus_out_q;
    assign bus_oe_o  = bus_oe_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer (NUM_CH=4, DW=8, PHASE_CYC=2): vector table plus
// hand sequences for round-robin, deferred soft reset, hard reset abort and pointer wrap.
module tb_rtc_bus_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  grant;
    logic        done;
    logic [7:0]  rdata;
    logic        busy;
    logic        rst_req;
    logic        rst_ack;
    logic        cs_n;
    logic        rd_n;
    logic        wr_n;
    logic        ad;
    logic [7:0]  bus_out;
    logic        bus_oe;
    logic [7:0]  bus_in;
    logic [7:0]  rd_val;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0] ch;
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] rdv;
        logic [7:0] rdx;
        logic [3:0] gnt;
    } vec_t;

    vec_t vecs[4];
    logic [3:0] exp3[5];

    always #5 clk = ~clk;

    // The RTC only drives valid read data while RD is low.
    assign bus_in = rd_n ? 8'hEE : rd_val;

    rtc_bus_sequencer #(
        .NUM_CH   (4),
        .DW       (8),
        .PHASE_CYC(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_i    (req),
        .we_i     (we),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .grant_o  (grant),
        .done_o   (done),
        .rdata_o  (rdata),
        .busy_o   (busy),
        .rst_req_i(rst_req),
        .rst_ack_o(rst_ack),
        .cs_n_o   (cs_n),
        .rd_n_o   (rd_n),
        .wr_n_o   (wr_n),
        .ad_o     (ad),
        .bus_out_o(bus_out),
        .bus_oe_o (bus_oe),
        .bus_in_i (bus_in)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_grant(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (grant != 4'b0000) seen = 1'b1;
        end
        chk({name, "_grant_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic drive(input logic [1:0] ch, input logic w, input logic [7:0] a,
                         input logic [7:0] d);
        req             = 4'b0001 << ch;
        we              = 4'b0000;
        we[ch]          = w;
        addr            = 32'h0;
        wdata           = 32'h0;
        addr[ch*8 +: 8]  = a;
        wdata[ch*8 +: 8] = d;
    endtask

    // {cs_n, rd_n, wr_n, ad, bus_oe, done, bus_out masked by bus_oe} for cycle n after grant.
    function automatic logic [13:0] exp_vec(input int n, input logic w, input logic [7:0] a,
                                            input logic [7:0] d);
        logic [7:0] dd;
        dd = w ? d : 8'h00;
        if (n == 13) return {3'b111, 1'b0, 1'b0, 1'b1, 8'h00};
        case ((n - 1) / 2)
            0, 2:    return {3'b111, 1'b0, 1'b1, 1'b0, a};
            1:       return {3'b010, 1'b0, 1'b1, 1'b0, a};
            3, 5:    return {3'b111, 1'b1, w, 1'b0, dd};
            default: return {1'b0, w, !w, 1'b1, w, 1'b0, dd};
        endcase
    endfunction

    function automatic logic [13:0] act_vec();
        return {cs_n, rd_n, wr_n, ad, bus_oe, done, bus_oe ? bus_out : 8'h00};
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        drive(v.ch, v.w, v.a, v.d);
        rd_val = v.rdv;
        wait_grant($sformatf("v%0d", idx));
        chk($sformatf("v%0d_grant", idx), 32'(grant), 32'(v.gnt));
        chk($sformatf("v%0d_busy", idx), 32'(busy), 32'd1);
        // Scramble inputs: the transaction must run on latched values.
        req   = 4'b0000;
        we    = ~we;
        addr  = 32'hFFFF_FFFF;
        wdata = 32'h5555_5555;
        for (int n = 1; n <= 13; n++) begin
            @(negedge clk);
            chk($sformatf("v%0d_cyc%0d", idx, n), 32'(act_vec()), 32'(exp_vec(n, v.w, v.a, v.d)));
        end
        chk($sformatf("v%0d_grant_at_done", idx), 32'(grant), 32'd0);
        chk($sformatf("v%0d_rdata", idx), 32'(rdata), 32'(v.rdx));
        @(negedge clk);
        chk($sformatf("v%0d_done_low", idx), 32'(done), 32'd0);
        chk($sformatf("v%0d_busy_low", idx), 32'(busy), 32'd0);
    endtask

    initial begin
        int gcount;
        vecs[0] = '{ch: 2'd1, w: 1'b1, a: 8'h21, d: 8'h15, rdv: 8'h00, rdx: 8'h00, gnt: 4'b0010};
        vecs[1] = '{ch: 2'd2, w: 1'b0, a: 8'h41, d: 8'h00, rdv: 8'h37, rdx: 8'h37, gnt: 4'b0100};
        vecs[2] = '{ch: 2'd0, w: 1'b1, a: 8'h5A, d: 8'hC3, rdv: 8'h00, rdx: 8'h37, gnt: 4'b0001};
        vecs[3] = '{ch: 2'd3, w: 1'b0, a: 8'h7E, d: 8'h00, rdv: 8'h9C, rdx: 8'h9C, gnt: 4'b1000};
`ifdef RTC_CH0_PRIO_EN
        exp3 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        exp3 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif

        reset   = 1'b1;
        req     = 4'b0000;
        we      = 4'b0000;
        addr    = 32'h0;
        wdata   = 32'h0;
        rst_req = 1'b0;
        rd_val  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_strobes", 32'({cs_n, rd_n, wr_n, ad, bus_oe, done}), 32'b111000);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_misc", 32'({busy, rst_ack, bus_out, rdata}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

        // Held requests on all channels rotate the grant.
        req = 4'b1111;
        we  = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant($sformatf("rr%0d", i));
            chk($sformatf("rr%0d_grant", i), 32'(grant), 32'(exp3[i]));
            if (i == 4) req = 4'b0000;
            wait_done($sformatf("rr%0d", i));
        end
        @(negedge clk);

        // Soft reset requested mid-transaction defers to the boundary.
        drive(2'd0, 1'b1, 8'h12, 8'h34);
        wait_grant("srst");
        chk("srst_grant", 32'(grant), 32'b0001);
        req = 4'b0000;
        repeat (3) @(negedge clk);
        chk("srst_in_astb", 32'(cs_n), 32'd0);
        rst_req = 1'b1;
        req     = 4'b1000;
        wait_done("srst");
        chk("srst_ack_at_done", 32'(rst_ack), 32'd0);
        @(negedge clk);
        chk("srst_ack", 32'(rst_ack), 32'd1);
        gcount = 0;
        repeat (10) begin
            @(negedge clk);
            if (grant != 4'b0000) gcount++;
        end
        chk("srst_no_grant", 32'(gcount), 32'd0);
        chk("srst_ack_held", 32'(rst_ack), 32'd1);
        rst_req = 1'b0;
        @(negedge clk);
        chk("srst_release_grant", 32'(grant), 32'b1000);
        chk("srst_ack_cleared", 32'(rst_ack), 32'd0);
        req = 4'b0000;
        wait_done("srst_release");
        @(negedge clk);

        // req and rst_req rising together: rst_req wins.
        req     = 4'b0010;
        rst_req = 1'b1;
        repeat (2) @(negedge clk);
        chk("same_cycle_grant", 32'(grant), 32'd0);
        chk("same_cycle_ack", 32'(rst_ack), 32'd1);
        req     = 4'b0000;
        rst_req = 1'b0;
        @(negedge clk);
        chk("same_cycle_ack_clr", 32'(rst_ack), 32'd0);

        // Hard reset during the read strobe aborts without done.
        drive(2'd2, 1'b0, 8'h44, 8'h00);
        rd_val = 8'h66;
        wait_grant("hrst");
        req = 4'b0000;
        repeat (9) @(negedge clk);
        chk("hrst_in_dstb", 32'({cs_n, rd_n}), 32'b00);
        reset = 1'b1;
        @(negedge clk);
        chk("hrst_strobes", 32'({cs_n, rd_n, wr_n, ad, bus_oe, done}), 32'b111000);
        chk("hrst_state", 32'({grant, busy, rdata}), 32'd0);
        reset = 1'b0;
        req   = 4'b1010;
        wait_grant("hrst_after");
        chk("hrst_first_grant", 32'(grant), 32'b0010);
        chk("hrst_no_done", 32'(done), 32'd0);
        req = 4'b0000;
        wait_done("hrst_after");
        @(negedge clk);

        // Pointer wrap after ch3, then ch0 just served with ch0/ch1 pending.
        drive(2'd3, 1'b1, 8'h30, 8'h31);
        wait_grant("wrap");
        chk("wrap_ch3", 32'(grant), 32'b1000);
        req = 4'b0011;
        wait_done("wrap_a");
        wait_grant("wrap_b");
        chk("wrap_next", 32'(grant), 32'b0001);
        wait_done("wrap_b");
        wait_grant("wrap_c");
`ifdef RTC_CH0_PRIO_EN
        chk("wrap_after_ch0", 32'(grant), 32'b0001);
`else
        chk("wrap_after_ch0", 32'(grant), 32'b0010);
`endif
        req = 4'b0000;
        wait_done("wrap_c");
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
